bridge_fifo: RTL

Parametrised synchronous circular-buffer FIFO. It buffers bytes (or wider words) between the I2C slave front-end and the UART transmitter of the bridge, and the reverse path. It replaces shift-register buffering with read/write pointers plus an occupancy counter. Status outputs: full, empty, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow errors. Optional first-word-fall-through (FWFT) read mode.

---
 rtl/bridge_pkg.sv | 20 ++
 rtl/bridge_fifo_mem.sv | 24 ++
 rtl/bridge_fifo.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared defaults and width helpers for the bridge datapath blocks.
package bridge_pkg;

  localparam int BRIDGE_DATA_W     = 8;
  localparam int BRIDGE_FIFO_DEPTH = 16;

  // Pointer width: ceil(log2(depth)), at least 1.
  function automatic int ptr_w(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

  // Occupancy counter width: one extra bit so DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/bridge_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read, no reset.
module bridge_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port; contents survive reset by design.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bridge_fifo.sv
// Circular-buffer FIFO between the I2C slave front-end and the UART path.
// Pointers plus occupancy counter; status derives from the counter only.
module bridge_fifo
  import bridge_pkg::*;
#(
  parameter int DATA_W    = BRIDGE_DATA_W,
  parameter int DEPTH     = BRIDGE_FIFO_DEPTH,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_en_write,
  input  logic                     i_en_read,
  input  logic                     i_flush,
  input  logic                     i_clr_err,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AEMPTY_TH);

  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow, r_underflow;
  logic              w_full, w_empty, w_rd_acc, w_wr_acc, w_we;
  logic [DATA_W-1:0] w_rdata;

  assign w_full   = (r_count == CNT_FULL);
  assign w_empty  = (r_count == '0);
  // A read frees a slot in the same cycle, so a full FIFO still takes a write.
  assign w_rd_acc = i_en_read & ~w_empty;
  assign w_wr_acc = i_en_write & (~w_full | w_rd_acc);
  assign w_we     = w_wr_acc & ~i_flush;

  bridge_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointers, occupancy and sticky errors; flush beats read/write and raises no errors.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      if (i_clr_err) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // Set has priority over clear.
      if (i_en_write & w_full & ~w_rd_acc) r_overflow <= 1'b1;
      else if (i_clr_err)                  r_overflow <= 1'b0;
      if (i_en_read & w_empty)             r_underflow <= 1'b1;
      else if (i_clr_err)                  r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg
      logic [DATA_W-1:0] r_data;
      logic              r_valid;
      // Registered read: capture the head on an accepted pop, valid for one cycle.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else if (i_flush) begin
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_rd_acc;
          if (w_rd_acc) r_data <= w_rdata;
        end
      end
      assign o_data  = r_data;
      assign o_valid = r_valid;
    end else begin : g_fwft
      // Head word is always presented; a read acknowledges it.
      assign o_data  = w_rdata;
      assign o_valid = ~w_empty;
    end
  endgenerate

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= CNT_AF);
  assign o_almost_empty = (r_count <= CNT_AE);
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule
